fir_lowpass: RTL and testbench

FIR_LOWPASS -- requirements
Module: fir_lowpass

---
 rtl/fir_pkg.sv | 63 ++++++
 rtl/fir_coeff_rom.sv | 27 ++
 rtl/fir_lowpass.sv | 137 +++++++++++++
 tb/tb_fir_lowpass.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_pkg                                                       |
// | Brief    : Shared widths, Q1.15 format constant, FSM state encoding and  |
// |            the constant function that builds the low-pass coefficients.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fir_pkg;

  localparam int     SAMPLE_W = 16;
  localparam int     COEFF_W  = 16;
  localparam int     Q_FRAC   = 15;
  localparam int     PROD_W   = SAMPLE_W + COEFF_W;
  localparam longint C_UNITY  = longint'(1) << Q_FRAC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Unnormalised windowed-sinc tap. u is twice the distance from the filter
  // centre (always odd). The sinc uses a parabolic sine approximation with
  // its first zero at u = n/2, and the window is Welch-shaped (n*n - u*u).
  function automatic longint coeff_raw(input int n, input int u);
    longint h;
    longint v;
    longint mag;
    h   = longint'(n / 2);
    v   = (longint'(u) < h) ? longint'(u) : longint'(u) - h;
    mag = (v * (h - v) * (longint'(n) * n - longint'(u) * u)) / longint'(u);
    return (longint'(u) < h) ? mag : -mag;
  endfunction

  // Tap scaled to Q1.15 against the total raw gain, truncated toward zero.
  function automatic longint coeff_scaled(input int n, input int u, input longint total);
    longint raw;
    longint mag;
    raw = coeff_raw(n, u);
    mag = ((raw < 0) ? -raw : raw) * C_UNITY / total;
    return (raw < 0) ? -mag : mag;
  endfunction

  // Coefficient for tap k of an n-tap filter. Truncation leftovers are
  // folded into the two centre taps so the taps sum to exactly 1.0 (32768).
  function automatic logic signed [COEFF_W-1:0] coeff_value(input int n, input int k);
    longint total;
    longint half;
    longint c;
    int     u;
    total = 0;
    half  = 0;
    for (int i = 1; i < n; i += 2) total += 2 * coeff_raw(n, i);
    for (int i = 1; i < n; i += 2) half += coeff_scaled(n, i, total);
    u = 2 * k + 1 - n;
    if (u < 0) u = -u;
    c = coeff_scaled(n, u, total);
    if (u == 1) c += (C_UNITY - 2 * half) / 2;
    return COEFF_W'(c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coeff_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_coeff_rom                                                 |
// | Brief    : Combinational Q1.15 coefficient lookup by tap index for the   |
// |            symmetric windowed-sinc low-pass.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fir_coeff_rom
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 16
) (
  input  logic [$clog2(NUM_TAPS)-1:0] tap_i,
  output logic signed [COEFF_W-1:0]   coeff_o
);

  logic signed [COEFF_W-1:0] rom_w [NUM_TAPS];

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_rom
    localparam logic signed [COEFF_W-1:0] C_TAP = coeff_value(NUM_TAPS, k);
    assign rom_w[k] = C_TAP;
  end

  assign coeff_o = rom_w[tap_i];

endmodule
`default_nettype wire

// File: rtl/fir_lowpass.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_lowpass                                                   |
// | Brief    : Sequential single-multiplier FIR low-pass. One sample in,     |
// |            NUM_TAPS MAC cycles, one output cycle.                        |
// |            Macro FIR_SAT_EN: saturate the output instead of wrapping.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fir_lowpass
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 16
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       ready_in,
  input  logic signed [SAMPLE_W-1:0] signal_in,
  output logic signed [SAMPLE_W-1:0] signal_out,
  output logic                       done_out,
  output logic                       busy_out,
  output logic                       overrun_out
);

  localparam int TAP_W = $clog2(NUM_TAPS);
  localparam int ACC_W = PROD_W + TAP_W;
  localparam logic [TAP_W-1:0] C_LAST_TAP = TAP_W'(NUM_TAPS - 1);

  state_e                     state_q;
  logic signed [SAMPLE_W-1:0] dline_q [NUM_TAPS];
  logic [TAP_W-1:0]           wptr_q;
  logic [TAP_W-1:0]           tap_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [SAMPLE_W-1:0] signal_out_q;
  logic                       done_q;
  logic                       busy_q;
  logic                       overrun_q;

  logic [TAP_W-1:0]           rd_idx_d;
  logic signed [SAMPLE_W-1:0] sample_d;
  logic signed [COEFF_W-1:0]  coeff_d;
  logic signed [PROD_W-1:0]   prod_d;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [SAMPLE_W-1:0] reduced_d;
  logic                       accept_d;

  fir_coeff_rom #(
    .NUM_TAPS (NUM_TAPS)
  ) u_coeff_rom (
    .tap_i   (tap_q),
    .coeff_o (coeff_d)
  );

  // Fetch sample[newest-k], form the single product and the next running sum
  always_comb begin
    rd_idx_d = wptr_q - TAP_W'(1) - tap_q;
    sample_d = dline_q[rd_idx_d];
    prod_d   = PROD_W'(sample_d) * PROD_W'(coeff_d);
    acc_d    = acc_q + ACC_W'(prod_d);
    accept_d = ready_in && ((state_q == IDLE) || (state_q == OUT));
  end

`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] C_OUT_MAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] C_OUT_MIN = ACC_W'(-(2 ** (SAMPLE_W - 1)));

  logic signed [ACC_W-1:0] shifted_d;

  // Drop the Q1.15 fraction and clamp into the 16-bit output range
  always_comb begin
    shifted_d = acc_q >>> Q_FRAC;
    if (shifted_d > C_OUT_MAX) begin
      reduced_d = C_OUT_MAX[SAMPLE_W-1:0];
    end else if (shifted_d < C_OUT_MIN) begin
      reduced_d = C_OUT_MIN[SAMPLE_W-1:0];
    end else begin
      reduced_d = shifted_d[SAMPLE_W-1:0];
    end
  end
`else
  // Drop the Q1.15 fraction and keep bits [30:15]; larger sums wrap
  always_comb begin
    reduced_d = acc_q[Q_FRAC+SAMPLE_W-1:Q_FRAC];
  end
`endif

  // Control FSM with delay line, accumulator and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      for (int i = 0; i < NUM_TAPS; i++) dline_q[i] <= '0;
      wptr_q       <= '0;
      tap_q        <= '0;
      acc_q        <= '0;
      signal_out_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        MAC: begin
          acc_q <= acc_d;
          tap_q <= tap_q + TAP_W'(1);
          // A strobe here cannot be taken; remember that it was lost
          if (ready_in) overrun_q <= 1'b1;
          if (tap_q == C_LAST_TAP) state_q <= OUT;
        end
        OUT: begin
          signal_out_q <= reduced_d;
          done_q       <= 1'b1;
          state_q      <= IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // A strobe in IDLE or OUT starts the next sample; overrides the return to IDLE
      if (accept_d) begin
        dline_q[wptr_q] <= signal_in;
        wptr_q          <= wptr_q + TAP_W'(1);
        acc_q           <= '0;
        tap_q           <= '0;
        state_q         <= MAC;
        busy_q          <= 1'b1;
      end
    end
  end

  assign signal_out  = signal_out_q;
  assign done_out    = done_q;
  assign busy_out    = busy_q;
  assign overrun_out = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_lowpass.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_lowpass                                                |
// | Brief    : Directed self-checking bench for fir_lowpass (16 taps).       |
// |            Honours FIR_SAT_EN for the saturation expectation.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fir_lowpass;

  localparam int NUM_TAPS = 16;
  localparam int LAT      = NUM_TAPS + 1;

`ifdef FIR_SAT_EN
  localparam int SAT_EXP = 32767;
`else
  localparam int SAT_EXP = -24622;
`endif

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               ready_in;
  logic signed [15:0] signal_in;
  logic signed [15:0] signal_out;
  logic               done_out;
  logic               busy_out;
  logic               overrun_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-derived Q1.15 taps of the 16-tap low-pass (sum 32768)
  int coeff_tab [NUM_TAPS] = '{-65, -469, -864, -639, 972, 3257, 5804, 8388,
                               8388, 5804, 3257, 972, -639, -864, -469, -65};

  fir_lowpass #(
    .NUM_TAPS (NUM_TAPS)
  ) u_dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .ready_in    (ready_in),
    .signal_in   (signal_in),
    .signal_out  (signal_out),
    .done_out    (done_out),
    .busy_out    (busy_out),
    .overrun_out (overrun_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Strobe one sample from IDLE, wait (bounded) for done, return signal_out
  task automatic run_sample(input int val, output int y);
    int cyc;
    ready_in  = 1'b1;
    signal_in = 16'(val);
    @(posedge clk_in); #1;
    ready_in  = 1'b0;
    signal_in = '0;
    check("busy_in_mac", int'(busy_out), 1);
    cyc = 0;
    while (!done_out && cyc < 40) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    check("latency", cyc, LAT);
    check("busy_at_done", int'(busy_out), 0);
    y = signal_out;
  endtask

  task automatic impulse_run(input string tag);
    int y;
    for (int n = 0; n < NUM_TAPS + 4; n++) begin
      run_sample((n == 0) ? 16384 : 0, y);
      check(tag, y, (n < NUM_TAPS) ? (coeff_tab[n] >>> 1) : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int y;
    int dcnt;
    int first;

    rst_in    = 1'b0;
    ready_in  = 1'b0;
    signal_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_signal_out", int'(signal_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_busy", int'(busy_out), 0);
    check("rst_overrun", int'(overrun_out), 0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // Impulse response, plus one-cycle done pulse width
    impulse_run("impulse");
    @(posedge clk_in); #1;
    check("done_width", int'(done_out), 0);

    // DC gain of exactly one once the line is full
    for (int n = 0; n < 3 * NUM_TAPS; n++) begin
      run_sample(1000, y);
      if (n == 0) check("dc_first", y, -2);
      if (n >= NUM_TAPS - 1) check("dc", y, 1000);
    end

    // Back-to-back strobes landing in OUT
    dcnt = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          ready_in  = 1'b1;
          signal_in = 16'sd1000;
          @(posedge clk_in); #1;
          ready_in  = 1'b0;
          repeat (NUM_TAPS) begin
            @(posedge clk_in); #1;
          end
        end
      end
      begin
        repeat (100 * LAT + 20) begin
          @(posedge clk_in); #1;
          if (done_out) dcnt++;
        end
      end
    join
    check("b2b_done_count", dcnt, 100);
    check("b2b_overrun", int'(overrun_out), 0);
    check("b2b_value", int'(signal_out), 1000);

    // Full-scale inputs matching every coefficient sign
    for (int j = 0; j < NUM_TAPS; j++) begin
      run_sample((coeff_tab[j] < 0) ? -32767 : 32767, y);
    end
    check("saturation", y, SAT_EXP);

    // Reset during MAC aborts the sample
    ready_in  = 1'b1;
    signal_in = 16'sd500;
    @(posedge clk_in); #1;
    ready_in  = 1'b0;
    signal_in = '0;
    dcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 8) rst_in = 1'b0;
      if (c == 10) rst_in = 1'b1;
      @(posedge clk_in); #1;
      if (done_out) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    check("abort_signal_out", int'(signal_out), 0);
    check("abort_busy", int'(busy_out), 0);
    check("abort_overrun", int'(overrun_out), 0);
    impulse_run("impulse_after_rst");

    // Strobe during MAC is dropped and flagged
    ready_in  = 1'b1;
    signal_in = 16'sd16384;
    @(posedge clk_in); #1;
    dcnt  = 0;
    first = -1;
    for (int c = 1; c <= 30; c++) begin
      ready_in  = (c == 5);
      signal_in = (c == 5) ? 16'sd12345 : 16'sd0;
      @(posedge clk_in); #1;
      if (done_out) begin
        dcnt++;
        if (first < 0) first = c;
      end
    end
    ready_in  = 1'b0;
    signal_in = '0;
    check("ovr_done_count", dcnt, 1);
    check("ovr_latency", first, LAT);
    check("ovr_flag", int'(overrun_out), 1);
    check("ovr_value", int'(signal_out), coeff_tab[0] >>> 1);
    run_sample(0, y);
    check("ovr_next_value", y, coeff_tab[1] >>> 1);
    check("ovr_sticky", int'(overrun_out), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
